// File: rtl/mc_core_param.sv
// Parametrised multi-cycle core: 10-opcode 32-bit ISA, req/ack instruction and data memories.
// Latency: ALU 4, LDR 5, STR 4, LDRI 3, JEQ/JNE 3 cycles with zero-wait memories; +1 per ack-wait cycle.
// Backpressure: each request is held (address/we/wdata stable) until its ack; one access outstanding at a time.
module mc_core_param #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               halted,
    output logic               trap,
    output logic [IMEM_AW-1:0] pc,
    output logic [CNT_W-1:0]   retire_count
);

    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b000100;
    localparam logic [5:0] OP_OR   = 6'b001000;
    localparam logic [5:0] OP_LDR  = 6'b100001;
    localparam logic [5:0] OP_STR  = 6'b100010;
    localparam logic [5:0] OP_LDRI = 6'b100100;
    localparam logic [5:0] OP_JNE  = 6'b111101;
    localparam logic [5:0] OP_JEQ  = 6'b111110;
    localparam logic [5:0] OP_EXIT = 6'b111111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t              state;
    logic [31:0]         ir;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    logic [DATA_W-1:0]   wb_val;
    logic [DMEM_AW-1:0]  daddr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [IMEM_AW-1:0]  pc_r;
    logic [CNT_W-1:0]    retire_r;
    logic                halted_r;
    logic                trap_r;
    logic [DATA_W-1:0]   rf [32];

    logic [5:0]          op;
    logic [DATA_W-1:0]   imm_sext;
    logic [DATA_W-1:0]   alu_res;
    logic                is_alu_op;
    logic                is_legal;
    logic [4:0]          wb_dst;
    logic [IMEM_AW-1:0]  pc_inc;

    assign op       = ir[31:26];
    assign imm_sext = DATA_W'($signed(ir[15:0]));
    assign pc_inc   = pc_r + IMEM_AW'(1);
    assign is_alu_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    // Register-register ops write rd; loads write rt.
    assign wb_dst   = is_alu_op ? ir[15:11] : ir[20:16];

    // Requests follow the state register and are forced low while reset is held,
    // so an in-flight handshake is dropped in the very cycle reset rises.
    assign imem_req     = (state == S_FETCH) && !reset;
    assign dmem_req     = (state == S_MEM) && !reset;
    assign dmem_we      = (state == S_MEM) && (op == OP_STR) && !reset;
    assign imem_addr    = pc_r;
    assign dmem_addr    = daddr_r;
    assign dmem_wdata   = wdata_r;
    assign pc           = pc_r;
    assign retire_count = retire_r;
    assign halted       = halted_r;
    assign trap         = trap_r;

    // Opcode legality decode of the latched instruction.
    always_comb begin
        is_legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDR, OP_STR,
            OP_LDRI, OP_JNE, OP_JEQ, OP_EXIT: is_legal = 1'b1;
            default:                          is_legal = 1'b0;
        endcase
    end

    // ALU: register ops on rs/rt operands, address generation for loads/stores.
    always_comb begin
        alu_res = a_r + b_r;
        case (op)
            OP_SUB:         alu_res = a_r - b_r;
            OP_AND:         alu_res = a_r & b_r;
            OP_OR:          alu_res = a_r | b_r;
            OP_LDR, OP_STR: alu_res = a_r + imm_sext;
            default:        alu_res = a_r + b_r;
        endcase
    end

    // Control FSM with datapath registers, register file and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            ir       <= '0;
            a_r      <= '0;
            b_r      <= '0;
            wb_val   <= '0;
            daddr_r  <= '0;
            wdata_r  <= '0;
            pc_r     <= '0;
            retire_r <= '0;
            halted_r <= 1'b0;
            trap_r   <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_r <= rf[ir[25:21]];
                    b_r <= rf[ir[20:16]];
                    if (op == OP_EXIT) begin
                        halted_r <= 1'b1;
                        state    <= S_HALT;
                    end else if (!is_legal) begin
                        halted_r <= 1'b1;
                        trap_r   <= 1'b1;
                        state    <= S_HALT;
                    end else if (op == OP_LDRI) begin
                        wb_val <= imm_sext;
                        state  <= S_WB;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op == OP_JEQ || op == OP_JNE) begin
                        if ((a_r == b_r) == (op == OP_JEQ)) pc_r <= ir[IMEM_AW-1:0];
                        else                                 pc_r <= pc_inc;
                        retire_r <= retire_r + CNT_W'(1);
                        state    <= S_FETCH;
                    end else if (op == OP_LDR || op == OP_STR) begin
                        daddr_r <= alu_res[DMEM_AW-1:0];
                        wdata_r <= b_r;
                        state   <= S_MEM;
                    end else begin
                        wb_val <= alu_res;
                        state  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (op == OP_STR) begin
                            pc_r     <= pc_inc;
                            retire_r <= retire_r + CNT_W'(1);
                            state    <= S_FETCH;
                        end else begin
                            wb_val <= dmem_rdata;
                            state  <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    rf[wb_dst] <= wb_val;
                    pc_r       <= pc_inc;
                    retire_r   <= retire_r + CNT_W'(1);
                    state      <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_core_param.sv
module tb_mc_core_param;

    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b000100;
    localparam logic [5:0] OP_OR   = 6'b001000;
    localparam logic [5:0] OP_LDR  = 6'b100001;
    localparam logic [5:0] OP_STR  = 6'b100010;
    localparam logic [5:0] OP_LDRI = 6'b100100;
    localparam logic [5:0] OP_JNE  = 6'b111101;
    localparam logic [5:0] OP_EXIT = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    // 32-bit core
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, trap;
    logic [7:0]  imem_addr, dmem_addr, pc;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, retire_count;

    // 16-bit core
    logic        imem_req16, dmem_req16, dmem_we16, halted16, trap16;
    logic [7:0]  imem_addr16, dmem_addr16, pc16;
    logic [15:0] dmem_wdata16;
    logic [31:0] retire_count16;
    logic [31:0] rom16 [4];

    mc_core_param dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .halted(halted), .trap(trap), .pc(pc), .retire_count(retire_count)
    );

    mc_core_param #(.DATA_W(16)) u16 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_ack(imem_req16),
        .imem_rdata(rom16[imem_addr16[1:0]]),
        .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
        .dmem_ack(dmem_req16), .dmem_rdata(16'h0000),
        .halted(halted16), .trap(trap16), .pc(pc16), .retire_count(retire_count16)
    );

    // Memory models with programmable wait states
    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    logic iack_force = 1'b0, dack_force = 1'b0;

    assign imem_ack   = (imem_req && (icnt >= iwait)) || iack_force;
    assign dmem_ack   = (dmem_req && (dcnt >= dwait)) || dack_force;
    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    int total = 0, bad = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Store scoreboard: expected stores are queued with the program, popped on each committed store
    typedef struct { logic [7:0] addr; logic [31:0] data; } st_t;
    st_t sb [$];

    always @(posedge clk) begin
        if (reset || !imem_req || imem_ack) icnt <= 0; else icnt <= icnt + 1;
        if (reset || !dmem_req || dmem_ack) dcnt <= 0; else dcnt <= dcnt + 1;
        if (!reset && dmem_req && dmem_ack && dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
            check("sb_store_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                st_t e;
                e = sb.pop_front();
                check("sb_store_addr", dmem_addr, e.addr);
                check("sb_store_data", dmem_wdata, e.data);
            end
        end
    end

    // Handshake monitor: pending requests hold stable; never both memories at once
    logic ip, dp, dw;
    logic [7:0] ia, da;
    logic [31:0] dd;
    always @(posedge clk) begin
        ip = imem_req && !imem_ack && !reset;
        ia = imem_addr;
        dp = dmem_req && !dmem_ack && !reset;
        da = dmem_addr; dw = dmem_we; dd = dmem_wdata;
        @(negedge clk);
        if (!reset) begin
            if (ip) begin
                check("ireq_hold", imem_req, 1);
                check("iaddr_hold", imem_addr, ia);
            end
            if (dp) begin
                check("dreq_hold", dmem_req, 1);
                check("daddr_hold", dmem_addr, da);
                check("dwe_hold", dmem_we, dw);
                check("dwdata_hold", dmem_wdata, dd);
            end
            if (imem_req || dmem_req) check("req_exclusive", imem_req && dmem_req, 0);
        end
    end

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction
    function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Counts edges after release until halted; an expired budget shows up as a halted check failing
    task automatic run_to_halt(input string nm, input int budget, output int cyc);
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, "_halted"}, halted, 1);
    endtask

    task automatic load_p1();
        clear_mem();
        imem[0] = ri(OP_LDRI, 1, 0, 5);
        imem[1] = ri(OP_LDRI, 2, 0, 3);
        imem[2] = rr(OP_SUB, 3, 1, 2);
        imem[3] = ri(OP_STR, 3, 0, 7);
        imem[4] = ri(OP_LDR, 4, 0, 7);
        imem[5] = {OP_EXIT, 26'd0};
        sb.push_back('{addr: 8'd7, data: 32'd2});
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [6];

    initial begin
        int cyc;

        vt[0] = '{op: OP_ADD, a: 16'h0005, b: 16'h0003, exp: 32'h0000_0008};
        vt[1] = '{op: OP_SUB, a: 16'h0003, b: 16'h0005, exp: 32'hFFFF_FFFE};
        vt[2] = '{op: OP_AND, a: 16'hF0F0, b: 16'h0FF0, exp: 32'h0000_00F0};
        vt[3] = '{op: OP_OR,  a: 16'h8000, b: 16'h0001, exp: 32'hFFFF_8001};
        vt[4] = '{op: OP_ADD, a: 16'h7FFF, b: 16'h7FFF, exp: 32'h0000_FFFE};
        vt[5] = '{op: OP_ADD, a: 16'hFFFF, b: 16'h0001, exp: 32'h0000_0000};

        rom16[0] = ri(OP_LDRI, 1, 0, -1);
        rom16[1] = ri(OP_LDRI, 2, 0, 1);
        rom16[2] = rr(OP_ADD, 3, 1, 2);
        rom16[3] = {OP_EXIT, 26'd0};

        // Reset with acks toggling, then basic program on zero-wait memories
        load_p1();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iack_force = i[0];
            dack_force = ~i[0];
            @(posedge clk); #1;
            check("rst_imem_req", imem_req, 0);
            check("rst_dmem_req", dmem_req, 0);
            check("rst_dmem_we", dmem_we, 0);
            check("rst_pc", pc, 0);
            check("rst_halted", halted, 0);
            check("rst_retire", retire_count, 0);
        end
        check("rst_dmem_addr", dmem_addr, 0);
        check("rst_dmem_wdata", dmem_wdata, 0);
        check("rst_trap", trap, 0);
        iack_force = 1'b0;
        dack_force = 1'b0;
        reset = 1'b0;
        #1;
        check("first_imem_req", imem_req, 1);
        check("first_imem_addr", imem_addr, 0);
        run_to_halt("p1", 100, cyc);
        check("p1_cycles", cyc, 21);
        check("p1_retire", retire_count, 5);
        check("p1_trap", trap, 0);
        check("p1_r4", dut.rf[4], 2);
        check("p1_pc", pc, 5);
        check("p1_sb_empty", sb.size(), 0);
        check("w16_halted", halted16, 1);
        check("w16_r1", u16.rf[1], 16'hFFFF);
        check("w16_r3_wrap", u16.rf[3], 16'h0000);
        check("w16_retire", retire_count16, 3);

        // Same program, 3 wait cycles on every fetch
        load_p1();
        iwait = 3;
        apply_reset(2);
        run_to_halt("wait", 200, cyc);
        check("wait_cycles", cyc, 39);
        check("wait_retire", retire_count, 5);
        check("wait_r4", dut.rf[4], 2);
        check("wait_sb_empty", sb.size(), 0);
        iwait = 0;

        // Branch loop
        clear_mem();
        imem[0] = ri(OP_LDRI, 1, 0, 3);
        imem[1] = ri(OP_LDRI, 2, 0, 1);
        imem[2] = ri(OP_LDRI, 5, 0, 0);
        imem[3] = rr(OP_SUB, 1, 1, 2);
        imem[4] = ri(OP_JNE, 5, 1, 3);
        imem[5] = {OP_EXIT, 26'd0};
        apply_reset(1);
        run_to_halt("loop", 200, cyc);
        check("loop_cycles", cyc, 32);
        check("loop_retire", retire_count, 9);
        check("loop_pc", pc, 5);
        check("loop_r1", dut.rf[1], 0);

        // Illegal opcode trap
        clear_mem();
        imem[0] = ri(OP_LDRI, 1, 0, 1);
        imem[1] = ri(OP_LDRI, 2, 0, 2);
        apply_reset(1);
        run_to_halt("trap", 100, cyc);
        check("trap_cycles", cyc, 8);
        check("trap_flag", trap, 1);
        check("trap_pc", pc, 2);
        check("trap_retire", retire_count, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("trap_no_fetch", imem_req, 0);
        end
        check("trap_pc_frozen", pc, 2);

        // Table-driven ALU vectors, results observed through the store scoreboard
        for (int i = 0; i < 6; i++) begin
            clear_mem();
            imem[0] = ri(OP_LDRI, 1, 0, int'(vt[i].a));
            imem[1] = ri(OP_LDRI, 2, 0, int'(vt[i].b));
            imem[2] = rr(vt[i].op, 3, 1, 2);
            imem[3] = ri(OP_STR, 3, 0, 10 + i);
            imem[4] = {OP_EXIT, 26'd0};
            sb.push_back('{addr: 8'(10 + i), data: vt[i].exp});
            apply_reset(1);
            run_to_halt("alu", 100, cyc);
            check("alu_cycles", cyc, 16);
            check("alu_retire", retire_count, 4);
            check("alu_sb_empty", sb.size(), 0);
        end

        // Reset during a stalled store, then a stray ack
        clear_mem();
        imem[0] = ri(OP_LDRI, 1, 0, 9);
        imem[1] = ri(OP_STR, 1, 0, 4);
        imem[2] = {OP_EXIT, 26'd0};
        dwait = 20;
        apply_reset(1);
        cyc = 0;
        while (!dmem_req && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("mr_reached_mem", dmem_req, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mr_dreq_drop", dmem_req, 0);
        check("mr_dwe_drop", dmem_we, 0);
        @(posedge clk); #1;
        check("mr_dreq_after", dmem_req, 0);
        check("mr_ireq_in_reset", imem_req, 0);
        check("mr_pc_reset", pc, 0);
        dwait = 0;
        sb.push_back('{addr: 8'd4, data: 32'd9});
        reset = 1'b0;
        dack_force = 1'b1;
        #1;
        check("mr_refetch_req", imem_req, 1);
        check("mr_refetch_addr", imem_addr, 0);
        @(posedge clk); #1;
        dack_force = 1'b0;
        run_to_halt("mr", 100, cyc);
        check("mr_cycles", cyc + 1, 9);
        check("mr_retire", retire_count, 2);
        check("mr_dmem4", dmem[4], 9);
        check("mr_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
